imem_loader: RTL and testbench

Serial program loader that writes the instruction memory the pipeline fetches from. It receives a framed byte stream on a UART line (8N1), assembles little-endian 32-bit words and writes them to consecutive word addresses, since the PC advances by 1 per instruction. While a load is in progress it holds the processor's PC in reset through `cpu_hold`. It sits beside the instruction memory in the top level, on the write side of the port the fetch stage reads.

---
 rtl/imem_loader.sv | 244 ++++++++++++++++++++++++
 tb/tb_imem_loader.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// UART (8N1) program loader: receives an A5-framed word stream and writes it into instruction memory,
// holding the CPU while loading. Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module imem_loader #(
  parameter int CLKS_PER_BIT = 868,
  parameter int ADDR_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              cpu_hold,
  output logic              done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_CNT  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [16:0]      MAX_WORDS = 17'(1) << ADDR_W;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  typedef enum logic [2:0] {
    L_IDLE   = 3'd0,
    L_CNT_LO = 3'd1,
    L_CNT_HI = 3'd2,
    L_DATA   = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    L_CSUM   = 3'd4,
`endif
    L_DONE   = 3'd5,
    L_ERR    = 3'd6
  } ld_state_t;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam ld_state_t FIN_STATE = L_CSUM;
`else
  localparam ld_state_t FIN_STATE = L_DONE;
`endif

  logic             r_rx_s1, r_rx_s2, r_rx_s3;
  logic             w_rx_fall;
  rx_state_t        r_rx_state, w_rx_next;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_rx_shift;
  logic             w_bit_end;
  logic             r_byte_valid;
  logic             r_frame_err;

  ld_state_t         r_state, w_next;
  logic [7:0]        r_cnt_lo;
  logic [15:0]       r_count;
  logic [15:0]       r_word_cnt;
  logic [1:0]        r_byte_idx;
  logic [31:0]       r_asm;
  logic              r_wr_en;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [31:0]       r_wr_data;
  logic              r_cpu_hold;
  logic              r_done;
  logic              r_err;
  logic [15:0]       w_count;
  logic              w_last_word;
  logic              w_sync;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        r_csum;
`endif

  // Three flops: two for metastability, the third only for falling-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
      r_rx_s3 <= 1'b1;
    end else begin
      r_rx_s1 <= rx;
      r_rx_s2 <= r_rx_s1;
      r_rx_s3 <= r_rx_s2;
    end
  end

  assign w_rx_fall = r_rx_s3 & ~r_rx_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rx_state <= RX_IDLE;
    else      r_rx_state <= w_rx_next;
  end

  always_comb begin
    w_rx_next = r_rx_state;
    w_bit_end = 1'b0;
    case (r_rx_state)
      RX_IDLE:  if (w_rx_fall) w_rx_next = RX_START;
      RX_START: begin
        w_bit_end = (r_clk_cnt == HALF_CNT);
        if (w_bit_end) w_rx_next = r_rx_s2 ? RX_IDLE : RX_DATA;
      end
      RX_DATA: begin
        w_bit_end = (r_clk_cnt == FULL_CNT);
        if (w_bit_end && r_bit_idx == 3'd7) w_rx_next = RX_STOP;
      end
      RX_STOP: begin
        w_bit_end = (r_clk_cnt == FULL_CNT);
        if (w_bit_end) w_rx_next = RX_IDLE;
      end
      default: w_rx_next = RX_IDLE;
    endcase
  end

  // byte_valid and frame_err are one-cycle strobes with no ready: the loader must take
  // each byte on its strobe cycle, and r_rx_shift holds it until the next start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_rx_shift   <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= (r_rx_state == RX_STOP) && w_bit_end && r_rx_s2;
      r_frame_err  <= (r_rx_state == RX_STOP) && w_bit_end && !r_rx_s2;
      if (r_rx_state == RX_IDLE || w_bit_end) r_clk_cnt <= '0;
      else                                    r_clk_cnt <= r_clk_cnt + 1'b1;
      if (r_rx_state == RX_START) r_bit_idx <= '0;
      if (r_rx_state == RX_DATA && w_bit_end) begin
        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
        r_bit_idx  <= r_bit_idx + 3'd1;
      end
    end
  end

  assign w_count     = {r_rx_shift, r_cnt_lo};
  assign w_last_word = (r_word_cnt + 16'd1 == r_count);
  assign w_sync      = r_byte_valid && (r_rx_shift == 8'hA5);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= L_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      L_IDLE:   if (w_sync) w_next = L_CNT_LO;
      L_CNT_LO: begin
        if (r_frame_err)       w_next = L_ERR;
        else if (r_byte_valid) w_next = L_CNT_HI;
      end
      L_CNT_HI: begin
        if (r_frame_err) w_next = L_ERR;
        else if (r_byte_valid) begin
          if ({1'b0, w_count} > MAX_WORDS) w_next = L_ERR;
          else if (w_count == 16'd0)       w_next = FIN_STATE;
          else                             w_next = L_DATA;
        end
      end
      L_DATA: begin
        if (r_frame_err) w_next = L_ERR;
        else if (r_byte_valid && r_byte_idx == 2'd3 && w_last_word) w_next = FIN_STATE;
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      L_CSUM: begin
        if (r_frame_err)       w_next = L_ERR;
        else if (r_byte_valid) w_next = (r_rx_shift == r_csum) ? L_DONE : L_ERR;
      end
`endif
      L_DONE:  w_next = L_IDLE;
      L_ERR:   w_next = L_IDLE;
      default: w_next = L_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt_lo   <= '0;
      r_count    <= '0;
      r_word_cnt <= '0;
      r_byte_idx <= '0;
      r_asm      <= '0;
      r_wr_en    <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_cpu_hold <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      r_csum     <= '0;
`endif
    end else begin
      r_wr_en <= 1'b0;
      if (r_wr_en) r_wr_addr <= r_wr_addr + 1'b1;
      case (r_state)
        L_IDLE: if (w_sync) begin
          r_cpu_hold <= 1'b1;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
          r_wr_addr  <= '0;
          r_word_cnt <= '0;
          r_byte_idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_csum     <= '0;
`endif
        end
        L_CNT_LO: if (r_byte_valid) r_cnt_lo <= r_rx_shift;
        L_CNT_HI: if (r_byte_valid) r_count  <= w_count;
        L_DATA: if (r_byte_valid) begin
          // Bytes enter at the top so the first one ends up in [7:0] after four shifts.
          r_asm      <= {r_rx_shift, r_asm[31:8]};
          r_byte_idx <= r_byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          r_csum     <= r_csum ^ r_rx_shift;
`endif
          if (r_byte_idx == 2'd3) begin
            r_wr_en    <= 1'b1;
            r_wr_data  <= {r_rx_shift, r_asm[31:8]};
            r_word_cnt <= r_word_cnt + 16'd1;
          end
        end
        L_DONE: begin
          r_cpu_hold <= 1'b0;
          r_done     <= 1'b1;
        end
        L_ERR: begin
          r_cpu_hold <= 1'b0;
          r_err      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign wr_en     = r_wr_en;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign cpu_hold  = r_cpu_hold;
  assign done      = r_done;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: UART byte driver, frame-level reference model feeding an expected-write queue,
// and a write monitor acting as scoreboard. Checksum scenarios are built when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  localparam int CPB = 16;
  localparam int AW  = 8;
  localparam int W   = AW + 32;

  typedef logic [7:0]  bq_t[$];
  typedef logic [31:0] wq_t[$];

  logic          clk = 1'b0;
  logic          rst;
  logic          rx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [31:0]   wr_data;
  logic          cpu_hold;
  logic          done;
  logic          err;
  logic [2:0]    dbg_state;

  int n_vec    = 0;
  int n_err    = 0;
  int n_writes = 0;
  logic [W-1:0] exp_q[$];

  logic [AW-1:0] last_addr;
  bit            chk_inc = 0;

  imem_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .rx(rx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err(err), .dbg_state(dbg_state)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, n_vec=%0d", n_vec);
    $fatal(1, "watchdog");
  end

  // scoreboard: every write must match the head of exp_q, occur under cpu_hold,
  // and the address must advance by one on the following cycle
  always @(negedge clk) begin
    if (rst !== 1'b1) chk_inc = 0;
    else begin
      if (chk_inc) begin
        chk_inc = 0;
        n_vec++;
        if (wr_addr !== AW'(last_addr + 1'b1)) begin
          n_err++;
          $display("FAIL addr_inc: got %0h want %0h", wr_addr, AW'(last_addr + 1'b1));
        end
      end
      if (wr_en === 1'b1) begin
        n_writes++;
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_write: got addr %0h data %08h, want no write", wr_addr, wr_data);
        end else begin
          logic [W-1:0] e;
          e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== e) begin
            n_err++;
            $display("FAIL write: got %0h:%08h want %0h:%08h", wr_addr, wr_data, e[W-1:32], e[31:0]);
          end
        end
        n_vec++;
        if (cpu_hold !== 1'b1) begin
          n_err++;
          $display("FAIL hold_at_write: got %b want 1", cpu_hold);
        end
        last_addr = wr_addr;
        chk_inc   = 1;
      end
    end
  end

  // driver tasks
  task automatic send_byte(input logic [7:0] b, input bit good_stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = good_stop;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic send_load(input bq_t fr, input bit bad_tail, input int gap, output bit to);
    foreach (fr[i]) begin
      send_byte(fr[i], 1'b1);
      repeat (gap) @(negedge clk);
    end
    if (bad_tail) send_byte(8'h3C, 1'b0);
    to = 1;
    for (int i = 0; i < 4 * CPB; i++) begin
      if ((done | err) === 1'b1) begin
        to = 0;
        break;
      end
      @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic bq_t build_frame(input logic [15:0] n, input wq_t words);
    bq_t f;
    logic [7:0] x;
    f = {};
    x = 8'h00;
    f.push_back(8'hA5);
    f.push_back(n[7:0]);
    f.push_back(n[15:8]);
    foreach (words[i]) begin
      for (int k = 0; k < 4; k++) begin
        logic [7:0] b;
        b = words[i][8*k +: 8];
        f.push_back(b);
        x ^= b;
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    f.push_back(x);
`endif
    return f;
  endfunction

  // reference model: parse the byte list by the frame rules, queue expected writes, predict done/err
  task automatic model_frame(input bq_t fr, output bit e_done, output bit e_err);
    int n;
    logic [7:0] x;
    e_done = 0;
    e_err  = 1;
    x      = 8'h00;
    n      = int'({fr[2], fr[1]});
    if (n > (1 << AW)) return;
    for (int w = 0; w < n; w++) begin
      if (fr.size() < 3 + 4*w + 4) return;
      exp_q.push_back({AW'(w), fr[3+4*w+3], fr[3+4*w+2], fr[3+4*w+1], fr[3+4*w]});
      for (int k = 0; k < 4; k++) x ^= fr[3+4*w+k];
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    if (fr.size() <= 3 + 4*n) return;
    if (fr[3+4*n] != x) return;
`endif
    e_done = 1;
    e_err  = 0;
  endtask

  // scenarios
  task automatic test_reset();
    int w0;
    rst = 1'b0;
    rx  = 1'b1;
    repeat (4) @(negedge clk);
    n_vec++;
    if ({wr_en, wr_addr, wr_data, cpu_hold, done, err, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got en=%b a=%0h d=%08h h=%b dn=%b er=%b st=%0d want all 0",
               wr_en, wr_addr, wr_data, cpu_hold, done, err, dbg_state);
    end
    rst = 1'b1;
    w0 = n_writes;
    repeat (20 * CPB) @(negedge clk);
    n_vec++;
    if (n_writes != w0 || cpu_hold !== 1'b0 || dbg_state !== 3'd0) begin
      n_err++;
      $display("FAIL reset_idle: got writes=%0d hold=%b st=%0d want 0 0 0", n_writes - w0, cpu_hold, dbg_state);
    end
  endtask

  task automatic test_basic_load();
    bq_t fr;
    wq_t w;
    bit ed, ee, to;
    int w0;
    w.push_back(32'h00000013);
    w.push_back(32'h00100093);
    fr = build_frame(16'd2, w);
    model_frame(fr, ed, ee);
    w0 = n_writes;
    send_byte(fr.pop_front(), 1'b1);
    n_vec++;
    if (cpu_hold !== 1'b1) begin
      n_err++;
      $display("FAIL basic_hold_after_sync: got %b want 1", cpu_hold);
    end
    send_load(fr, 1'b0, 0, to);
    n_vec++;
    if (to || done !== ed || err !== ee || cpu_hold !== 1'b0) begin
      n_err++;
      $display("FAIL basic_end: got to=%b done=%b err=%b hold=%b want 0 %b %b 0", to, done, err, cpu_hold, ed, ee);
    end
    n_vec++;
    if (n_writes - w0 != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL basic_writes: got %0d (pending %0d) want 2 (0)", n_writes - w0, exp_q.size());
    end
  endtask

`ifdef IMEM_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    bq_t fr;
    wq_t w;
    bit ed, ee, to;
    int w0;
    w.push_back(32'h00000013);
    w.push_back(32'h00100093);
    fr = build_frame(16'd2, w);
    fr[fr.size()-1] = fr[fr.size()-1] ^ 8'h01;
    model_frame(fr, ed, ee);
    w0 = n_writes;
    send_load(fr, 1'b0, 0, to);
    n_vec++;
    if (to || err !== 1'b1 || done !== 1'b0 || ee !== 1'b1 || cpu_hold !== 1'b0) begin
      n_err++;
      $display("FAIL csum_bad: got to=%b done=%b err=%b hold=%b want 0 0 1 0", to, done, err, cpu_hold);
    end
    n_vec++;
    if (n_writes - w0 != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL csum_bad_writes: got %0d want 2", n_writes - w0);
    end
  endtask
`endif

  task automatic test_framing_abort();
    bq_t fr;
    wq_t w;
    bit ed, ee, to;
    int w0;
    fr = '{8'hA5, 8'h01, 8'h00, 8'hEF};
    model_frame(fr, ed, ee);
    w0 = n_writes;
    send_load(fr, 1'b1, 0, to);
    n_vec++;
    if (to || err !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b0 || n_writes != w0) begin
      n_err++;
      $display("FAIL abort: got to=%b err=%b done=%b hold=%b writes=%0d want 0 1 0 0 0",
               to, err, done, cpu_hold, n_writes - w0);
    end
    w.push_back($urandom);
    fr = build_frame(16'd1, w);
    model_frame(fr, ed, ee);
    send_load(fr, 1'b0, 0, to);
    n_vec++;
    if (to || err !== 1'b0 || done !== 1'b1 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL abort_recover: got to=%b err=%b done=%b pending=%0d want 0 0 1 0", to, err, done, exp_q.size());
    end
  endtask

  task automatic test_bounds();
    bq_t fr;
    wq_t w;
    bit ed, ee, to;
    int w0;
    fr = '{8'hA5, 8'h01, 8'h01};
    model_frame(fr, ed, ee);
    w0 = n_writes;
    send_load(fr, 1'b0, 0, to);
    n_vec++;
    if (to || err !== 1'b1 || done !== 1'b0 || n_writes != w0) begin
      n_err++;
      $display("FAIL too_many: got to=%b err=%b done=%b writes=%0d want 0 1 0 0", to, err, done, n_writes - w0);
    end
    fr = build_frame(16'd0, w);
    model_frame(fr, ed, ee);
    send_load(fr, 1'b0, 0, to);
    n_vec++;
    if (to || done !== 1'b1 || err !== 1'b0 || cpu_hold !== 1'b0 || n_writes != w0) begin
      n_err++;
      $display("FAIL zero_count: got to=%b done=%b err=%b hold=%b writes=%0d want 0 1 0 0 0",
               to, done, err, cpu_hold, n_writes - w0);
    end
  endtask

  task automatic test_reset_mid_load();
    bq_t fr;
    wq_t w;
    bit ed, ee, to;
    int w0;
    w0 = n_writes;
    fr = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22};
    foreach (fr[i]) send_byte(fr[i], 1'b1);
    n_vec++;
    if (cpu_hold !== 1'b1) begin
      n_err++;
      $display("FAIL mid_hold_before_rst: got %b want 1", cpu_hold);
    end
    #2 rst = 1'b0;
    #1;
    n_vec++;
    if ({wr_en, wr_addr, wr_data, cpu_hold, done, err, dbg_state} !== '0) begin
      n_err++;
      $display("FAIL mid_reset_outputs: got en=%b a=%0h d=%08h h=%b dn=%b er=%b st=%0d want all 0",
               wr_en, wr_addr, wr_data, cpu_hold, done, err, dbg_state);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    w.push_back($urandom);
    w.push_back($urandom);
    fr = build_frame(16'd2, w);
    model_frame(fr, ed, ee);
    send_load(fr, 1'b0, 0, to);
    n_vec++;
    if (to || done !== 1'b1 || n_writes - w0 != 2 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL mid_fresh_load: got to=%b done=%b writes=%0d pending=%0d want 0 1 2 0",
               to, done, n_writes - w0, exp_q.size());
    end
  endtask

  task automatic test_glitch_noise();
    bq_t fr;
    wq_t w;
    bit ed, ee, to;
    logic [7:0] noise[3];
    int w0;
    rx = 1'b0;
    repeat (CPB * 3 / 10) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    w.push_back($urandom);
    fr = build_frame(16'd1, w);
    model_frame(fr, ed, ee);
    send_load(fr, 1'b0, 0, to);
    n_vec++;
    if (to || done !== 1'b1 || err !== 1'b0 || exp_q.size() != 0) begin
      n_err++;
      $display("FAIL glitch_then_load: got to=%b done=%b err=%b pending=%0d want 0 1 0 0", to, done, err, exp_q.size());
    end
    noise = '{8'h00, 8'hFF, 8'h5A};
    w0 = n_writes;
    foreach (noise[i]) begin
      send_byte(noise[i], 1'b1);
      repeat (4) @(negedge clk);
      n_vec++;
      if (cpu_hold !== 1'b0 || dbg_state !== 3'd0 || done !== 1'b1 || n_writes != w0) begin
        n_err++;
        $display("FAIL noise_%0d: got hold=%b st=%0d done=%b writes=%0d want 0 0 1 0",
                 i, cpu_hold, dbg_state, done, n_writes - w0);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 4; t++) begin
      bq_t fr;
      wq_t w;
      bit ed, ee, to;
      int n, w0;
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) w.push_back($urandom);
      fr = build_frame(16'(n), w);
      model_frame(fr, ed, ee);
      w0 = n_writes;
      send_load(fr, 1'b0, (t == 0) ? 0 : $urandom_range(0, 3), to);
      n_vec++;
      if (to || done !== 1'b1 || err !== 1'b0 || n_writes - w0 != n || exp_q.size() != 0) begin
        n_err++;
        $display("FAIL random_load_%0d: got to=%b done=%b err=%b writes=%0d pending=%0d want 0 1 0 %0d 0",
                 t, to, done, err, n_writes - w0, exp_q.size(), n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    test_framing_abort();
    test_bounds();
    test_reset_mid_load();
    test_glitch_noise();
    test_back_to_back();
    repeat (10) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
